// File: rtl/blinky_array.sv
// rtl/blinky_array.sv - multi-channel LED pattern generator with shared tick prescaler
//
// Optional feature macro: BLINKY_SYNC_EN (adds io_sync phase-realign input).
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       synchronous active-low reset
//   io_wr_en      one-cycle channel write strobe
//   io_wr_chan    target channel of the write
//   io_wr_mode    0 OFF, 1 ON, 2 BLINK, 3 PULSE
//   io_wr_period  period value P for BLINK/PULSE
//   io_sync       phase realign of all BLINK channels (BLINKY_SYNC_EN only)
//   io_leds       registered LED outputs, bit c = channel c
//   io_busy       bit c high while channel c is in PULSE
module blinky_array #(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 500,
  parameter int PERIOD_W = 8,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                io_wr_en,
  input  logic [CW-1:0]       io_wr_chan,
  input  logic [1:0]          io_wr_mode,
  input  logic [PERIOD_W-1:0] io_wr_period,
`ifdef BLINKY_SYNC_EN
  input  logic                io_sync,
`endif
  output logic [CHANNELS-1:0] io_leds,
  output logic [CHANNELS-1:0] io_busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  // One extra bit so CHANNELS itself fits (e.g. 32 channels with a 5-bit index).
  localparam logic [CW:0]   CH_LIMIT = (CW + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  logic [PW-1:0]       pre_q, pre_d;
  mode_e               mode_q   [CHANNELS];
  mode_e               mode_d   [CHANNELS];
  logic [PERIOD_W-1:0] period_q [CHANNELS];
  logic [PERIOD_W-1:0] period_d [CHANNELS];
  logic [PERIOD_W-1:0] cnt_q    [CHANNELS];
  logic [PERIOD_W-1:0] cnt_d    [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;

  logic sync;
  logic tick;
  logic wr_hit;

`ifdef BLINKY_SYNC_EN
  assign sync = io_sync;
`else
  assign sync = 1'b0;
`endif

  always_comb begin
    wr_hit = io_wr_en && ({1'b0, io_wr_chan} < CH_LIMIT);
    // A sync cycle restarts the prescaler and suppresses the tick it would have made.
    tick   = (pre_q == PRE_MAX) && !sync;

    if (sync || (pre_q == PRE_MAX)) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    led_d = led_q;
    for (int c = 0; c < CHANNELS; c++) begin
      mode_d[c]   = mode_q[c];
      period_d[c] = period_q[c];
      cnt_d[c]    = cnt_q[c];

      if (tick) begin
        case (mode_q[c])
          MODE_OFF: begin
            led_d[c] = 1'b0;
            cnt_d[c] = '0;
          end
          MODE_ON: begin
            led_d[c] = 1'b1;
            cnt_d[c] = '0;
          end
          MODE_BLINK: begin
            if (cnt_q[c] == period_q[c]) begin
              cnt_d[c] = '0;
              led_d[c] = ~led_q[c];
            end else begin
              cnt_d[c] = cnt_q[c] + PERIOD_W'(1);
            end
          end
          MODE_PULSE: begin
            if (cnt_q[c] == period_q[c]) begin
              cnt_d[c]  = '0;
              led_d[c]  = 1'b0;
              mode_d[c] = MODE_OFF;
            end else begin
              cnt_d[c] = cnt_q[c] + PERIOD_W'(1);
            end
          end
        endcase
      end

      if (sync && (mode_q[c] == MODE_BLINK)) begin
        cnt_d[c] = '0;
        led_d[c] = 1'b1;
      end

      // Write is applied last so it overrides both the tick and the sync update.
      if (wr_hit && (io_wr_chan == CW'(c))) begin
        mode_d[c]   = mode_e'(io_wr_mode);
        period_d[c] = io_wr_period;
        cnt_d[c]    = '0;
        led_d[c]    = (io_wr_mode != MODE_OFF);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre_q <= '0;
      led_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]   <= MODE_OFF;
        period_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      pre_q <= pre_d;
      led_q <= led_d;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]   <= mode_d[c];
        period_q[c] <= period_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  assign io_leds = led_q;

  always_comb begin
    io_busy = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      io_busy[c] = (mode_q[c] == MODE_PULSE);
    end
  end

endmodule

// File: tb/tb_blinky_array.sv
// tb/tb_blinky_array.sv - self-checking bench for blinky_array
module tb_blinky_array;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_PULSE = 2'd3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_chan = '0;
  logic [1:0] wr_mode = '0;
  logic [3:0] wr_period = '0;
  logic       sync = 1'b0;
  logic [3:0] leds, busy;

  logic       wr3_en = 1'b0;
  logic [1:0] wr3_chan = '0;
  logic [1:0] wr3_mode = '0;
  logic [3:0] wr3_period = '0;
  logic [2:0] leds3, busy3;

  always #5 clock = ~clock;

  blinky_array #(.CHANNELS(4), .PRESCALE(4), .PERIOD_W(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_wr_en     (wr_en),
    .io_wr_chan   (wr_chan),
    .io_wr_mode   (wr_mode),
    .io_wr_period (wr_period),
`ifdef BLINKY_SYNC_EN
    .io_sync      (sync),
`endif
    .io_leds      (leds),
    .io_busy      (busy)
  );

  blinky_array #(.CHANNELS(3), .PRESCALE(4), .PERIOD_W(4)) dut3 (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_wr_en     (wr3_en),
    .io_wr_chan   (wr3_chan),
    .io_wr_mode   (wr3_mode),
    .io_wr_period (wr3_period),
`ifdef BLINKY_SYNC_EN
    .io_sync      (1'b0),
`endif
    .io_leds      (leds3),
    .io_busy      (busy3)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] chan;
    logic [1:0] mode;
    logic [3:0] per;
    int         reps;
    logic [3:0] exp_leds;
    logic [3:0] exp_busy;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] leds;
    logic [3:0] busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic void add(input logic rst, input logic en, input logic [1:0] ch,
                              input logic [1:0] mode, input logic [3:0] per,
                              input logic [3:0] el, input logic [3:0] eb, input int reps);
    vec_t v;
    v.rst_n = rst; v.en = en; v.chan = ch; v.mode = mode; v.per = per;
    v.exp_leds = el; v.exp_busy = eb; v.reps = reps;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic en, input logic [1:0] ch,
                      input logic [1:0] mode, input logic [3:0] per, input logic syn,
                      input logic [3:0] el, input logic [3:0] eb);
    exp_t e;
    reset_n = rst; wr_en = en; wr_chan = ch; wr_mode = mode; wr_period = per; sync = syn;
    wr3_en = 1'b0;
    e.name = name; e.leds = el; e.busy = eb;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    e = sb.pop_front();
    check({e.name, " leds"}, leds, e.leds);
    check({e.name, " busy"}, busy, e.busy);
    wr_en = 1'b0;
    sync = 1'b0;
  endtask

  task automatic step3(input string name, input logic en, input logic [1:0] ch,
                       input logic [1:0] mode, input logic [3:0] per,
                       input logic [2:0] el, input logic [2:0] eb);
    exp_t e;
    reset_n = 1'b1; wr_en = 1'b0;
    wr3_en = en; wr3_chan = ch; wr3_mode = mode; wr3_period = per;
    e.name = name; e.leds = {1'b0, el}; e.busy = {1'b0, eb};
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    e = sb.pop_front();
    check({e.name, " leds"}, {1'b0, leds3}, e.leds);
    check({e.name, " busy"}, {1'b0, busy3}, e.busy);
    wr3_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset, then cycle numbers are edges counted from the first edge with reset_n high
    add(0, 0, 0, M_OFF,   0, 4'b0000, 4'b0000, 3);
    add(1, 1, 2, M_PULSE, 2, 4'b0100, 4'b0100, 4);  // 0-3
    add(1, 1, 0, M_BLINK, 1, 4'b0101, 4'b0100, 3);  // 4-6
    add(1, 1, 1, M_ON,    0, 4'b0111, 4'b0100, 4);  // 7 tick+write, 7-10
    add(1, 0, 0, M_OFF,   0, 4'b0010, 4'b0000, 8);  // 11-18 pulse ends, ch0 off-phase
    add(1, 0, 0, M_OFF,   0, 4'b0011, 4'b0000, 1);  // 19
    add(1, 1, 3, M_BLINK, 0, 4'b1011, 4'b0000, 3);  // 20-22
    add(1, 0, 0, M_OFF,   0, 4'b0011, 4'b0000, 4);  // 23-26
    add(1, 0, 0, M_OFF,   0, 4'b1010, 4'b0000, 1);  // 27
    add(1, 1, 3, M_PULSE, 0, 4'b1010, 4'b1000, 3);  // 28-30
    add(1, 0, 0, M_OFF,   0, 4'b0010, 4'b0000, 1);  // 31 P=0 pulse ends on first tick
    add(1, 1, 2, M_BLINK, 0, 4'b0110, 4'b0000, 1);  // 32
    add(0, 1, 0, M_ON,    0, 4'b0000, 4'b0000, 2);  // mid-operation reset beats write
    add(1, 1, 0, M_BLINK, 0, 4'b0001, 4'b0000, 3);  // 0-2 prescaler restarted
    add(1, 0, 0, M_OFF,   0, 4'b0000, 4'b0000, 4);  // 3-6
    add(1, 0, 0, M_OFF,   0, 4'b0001, 4'b0000, 1);  // 7
    add(1, 1, 0, M_OFF,   5, 4'b0000, 4'b0000, 4);  // 8-11
    add(1, 1, 1, M_PULSE, 1, 4'b0010, 4'b0010, 7);  // 12-18
    add(1, 0, 0, M_OFF,   0, 4'b0000, 4'b0000, 1);  // 19
    add(1, 1, 0, M_BLINK, 0, 4'b0001, 4'b0000, 1);  // 20
    add(1, 1, 2, M_BLINK, 0, 4'b0101, 4'b0000, 2);  // 21-22
    add(1, 1, 0, M_BLINK, 0, 4'b0001, 4'b0000, 4);  // 23 write wins on ch0, ch2 still ticks
    add(1, 0, 0, M_OFF,   0, 4'b0100, 4'b0000, 1);  // 27

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step($sformatf("vec%0d.%0d", i, r), vecs[i].rst_n,
             (r == 0) ? vecs[i].en : 1'b0, vecs[i].chan, vecs[i].mode, vecs[i].per,
             1'b0, vecs[i].exp_leds, vecs[i].exp_busy);
      end
    end

`ifdef BLINKY_SYNC_EN
    step("sy_rst", 0, 0, 0, M_OFF,   0, 0, 4'b0000, 4'b0000);
    step("sy_c0",  1, 1, 0, M_BLINK, 0, 0, 4'b0001, 4'b0000);
    step("sy_c1",  1, 1, 1, M_BLINK, 3, 0, 4'b0011, 4'b0000);
    step("sy_c2",  1, 0, 0, M_OFF,   0, 0, 4'b0011, 4'b0000);
    step("sy_c3",  1, 0, 0, M_OFF,   0, 0, 4'b0010, 4'b0000);
    step("sy_c4",  1, 0, 0, M_OFF,   0, 1, 4'b0011, 4'b0000);
    step("sy_c5",  1, 0, 0, M_OFF,   0, 0, 4'b0011, 4'b0000);
    step("sy_c6",  1, 0, 0, M_OFF,   0, 0, 4'b0011, 4'b0000);
    step("sy_c7",  1, 0, 0, M_OFF,   0, 0, 4'b0011, 4'b0000);
    step("sy_c8",  1, 0, 0, M_OFF,   0, 0, 4'b0010, 4'b0000);
    step("sy_c9",  1, 1, 0, M_ON,    0, 1, 4'b0011, 4'b0000);
`endif

    // Three-channel build: channel index 3 is out of range and must change nothing.
    step("r3_rst", 0, 0, 0, M_OFF, 0, 0, 4'b0000, 4'b0000);
    step3("r3_c0",  1, 2, M_ON,    0, 3'b100, 3'b000);
    step3("r3_c1",  1, 3, M_OFF,   0, 3'b100, 3'b000);
    step3("r3_c2",  1, 3, M_BLINK, 0, 3'b100, 3'b000);
    step3("r3_c3",  1, 0, M_BLINK, 0, 3'b101, 3'b000);
    step3("r3_c4",  0, 0, M_OFF,   0, 3'b101, 3'b000);
    step3("r3_c5",  0, 0, M_OFF,   0, 3'b101, 3'b000);
    step3("r3_c6",  0, 0, M_OFF,   0, 3'b101, 3'b000);
    step3("r3_c7",  0, 0, M_OFF,   0, 3'b100, 3'b000);
    step3("r3_c8",  1, 3, M_PULSE, 2, 3'b100, 3'b000);
    step3("r3_c9",  0, 0, M_OFF,   0, 3'b100, 3'b000);
    step3("r3_c10", 0, 0, M_OFF,   0, 3'b100, 3'b000);
    step3("r3_c11", 1, 3, M_ON,    0, 3'b101, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
